// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit (and future receive) path.
//   - DATA_BITS / LINE_IDLE : frame constants (8 data bits, line idles high)
//   - ST_* localparams      : state encoding shared by TX and RX sequencers
//   - state_t               : enum built on the ST_* encoding
//   - cnt_width()           : counter width helper (ceil(log2(n)), min 1)
// Ports: none (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_t;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_div.sv
// -----------------------------------------------------------------------------
// uart_baud_div
// Bit-period divider. Counts 0..CLKS_PER_BIT-1 while run is high and wraps;
// bit_tick is high during the wrap cycle so the sequencer advances on the
// edge that ends each bit period.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   clear    in   force count to 0 (takes priority over run)
//   run      in   count enable
//   bit_tick out  one-cycle pulse in the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_div
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (run) begin
            if (count_reg == LAST) begin
                count_next = '0;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    assign bit_tick = run && !clear && (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
// Serializes an E_BITS-wide datapath word over an 8N1 UART line, low byte
// first, each byte LSB first. Consecutive bytes of a word are sent with no
// idle gap; after the last stop bit o_done pulses for one cycle, in which a
// new word may already be accepted.
// Optional build macro UART_TX_PARITY_EN: inserts an even-parity bit between
// the last data bit and the stop bit (11-bit frames).
// Ports:
//   i_clk    in   system clock, rising edge
//   i_rst_n  in   synchronous active-low reset
//   i_valid  in   word on i_data is offered
//   i_data   in   word to transmit (E_BITS)
//   o_ready  out  a word can be accepted this cycle
//   o_busy   out  frame sequence in progress
//   o_done   out  one-cycle pulse after the last stop bit
//   o_tx     out  serial line, idle high, driven from a flop
// -----------------------------------------------------------------------------
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int E_BITS       = 16,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [E_BITS-1:0] i_data,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_tx
);

    localparam int                NBYTES    = E_BITS / DATA_BITS;
    localparam int                BYTE_W    = cnt_width(NBYTES);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

    state_t              state_reg,    state_next;
    logic [2:0]          bit_idx_reg,  bit_idx_next;
    logic [BYTE_W-1:0]   byte_idx_reg, byte_idx_next;
    logic [E_BITS-1:0]   shift_reg,    shift_next;
    logic                tx_reg,       tx_next;
    logic                done_reg,     done_next;

    logic                bit_tick;
    logic                div_clear;
    logic [7:0]          cur_byte;

    // The divider sits at zero while idle, so the first START bit gets a
    // full period counted from the transfer edge.
    assign div_clear = (state_reg == S_IDLE);

    uart_baud_div #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_div (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (div_clear),
        .run     (!div_clear),
        .bit_tick(bit_tick)
    );

    // The byte on the wire is always the low byte of the shift register.
    assign cur_byte = shift_reg[7:0];

    // tx_next is the line level for the state being entered, so the pin
    // changes exactly on the edge where the state does.
    always_comb begin
        state_next    = state_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        done_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                tx_next = LINE_IDLE;
                if (i_valid) begin
                    state_next    = S_START;
                    bit_idx_next  = '0;
                    byte_idx_next = '0;
                    shift_next    = i_data;
                    tx_next       = 1'b0;
                end
            end

            S_START: begin
                if (bit_tick) begin
                    state_next   = S_DATA;
                    bit_idx_next = '0;
                    tx_next      = cur_byte[0];
                end
            end

            S_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
                        tx_next    = ^cur_byte;
`else
                        state_next = S_STOP;
                        tx_next    = LINE_IDLE;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = cur_byte[bit_idx_reg + 3'd1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    state_next = S_STOP;
                    tx_next    = LINE_IDLE;
                end
            end
`endif

            S_STOP: begin
                if (bit_tick) begin
                    if (byte_idx_reg != LAST_BYTE) begin
                        state_next    = S_START;
                        byte_idx_next = byte_idx_reg + 1'b1;
                        shift_next    = shift_reg >> DATA_BITS;
                        tx_next       = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                        tx_next    = LINE_IDLE;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
                tx_next    = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg    <= S_IDLE;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            tx_reg       <= LINE_IDLE;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
        end
    end

    assign o_ready = (state_reg == S_IDLE);
    assign o_busy  = (state_reg != S_IDLE);
    assign o_done  = done_reg;
    assign o_tx    = tx_reg;

endmodule

// File: tb/tb_uart_word_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_word_tx
// Self-checking bench for uart_word_tx (E_BITS=16, CLKS_PER_BIT=4).
// Each word case is a table record; the bench builds the expected per-cycle
// waveform of o_tx/o_done/o_busy/o_ready from the frame format, captures the
// DUT outputs one cycle at a time and compares the whole trace.
// -----------------------------------------------------------------------------
module tb_uart_word_tx;

    localparam int E_BITS = 16;
    localparam int CPB    = 4;
    localparam int NB     = E_BITS / 8;
`ifdef UART_TX_PARITY_EN
    localparam int F      = 11;
`else
    localparam int F      = 10;
`endif
    localparam int T      = NB * F * CPB;
    localparam int MAXC   = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data  = 16'h0000;
    logic        ready, busy, done, tx;

    always #5 clk = ~clk;

    uart_word_tx #(
        .E_BITS      (E_BITS),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(valid),
        .i_data (data),
        .o_ready(ready),
        .o_busy (busy),
        .o_done (done),
        .o_tx   (tx)
    );

    int checks   = 0;
    int failures = 0;

    logic [MAXC-1:0] cap_tx, cap_done, cap_busy, cap_ready;
    logic [MAXC-1:0] exp_tx, exp_done, exp_busy, exp_ready;

    typedef struct {
        string       name;
        logic [15:0] d0;
        bit          hold;    // keep i_valid high and offer d1 next
        logic [15:0] d1;
        int          pulse_c; // cycle with a stray 0xFFFF offer (0 = none)
        int          rst_c;   // cycle with i_rst_n low (0 = none)
        int          ncyc;
    } vec_t;

    vec_t vecs[6];
    int   nvec;

    // Idle line everywhere.
    task automatic exp_init();
        for (int c = 0; c < MAXC; c++) begin
            exp_tx[c]    = 1'b1;
            exp_done[c]  = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_ready[c] = 1'b1;
        end
    endtask

    // Word whose START bit begins in cycle s.
    task automatic exp_word(input logic [15:0] w, input int s);
        int   c;
        logic b;
        logic [7:0] by;
        c = s;
        for (int k = 0; k < NB; k++) begin
            by = w[8*k +: 8];
            for (int j = 0; j < F; j++) begin
                if (j == 0)                b = 1'b0;
                else if (j <= 8)           b = by[j-1];
                else if (j == 9 && F == 11) b = ^by;
                else                       b = 1'b1;
                for (int m = 0; m < CPB; m++) begin
                    exp_tx[c]    = b;
                    exp_busy[c]  = 1'b1;
                    exp_ready[c] = 1'b0;
                    c = c + 1;
                end
            end
        end
        exp_done[c] = 1'b1;
    endtask

    task automatic exp_reset_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            exp_tx[c]    = 1'b1;
            exp_done[c]  = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_ready[c] = 1'b1;
        end
    endtask

    // Samples cycles 1..n, starting #1 after the current edge.
    task automatic capture(input int n, input int pulse_c, input int rst_c, input int drop_c);
        for (int c = 1; c <= n; c++) begin
            if (c == pulse_c) begin
                valid = 1'b1;
                data  = 16'hFFFF;
            end
            if (c == rst_c) rst_n = 1'b0;
            cap_tx[c]    = tx;
            cap_done[c]  = done;
            cap_busy[c]  = busy;
            cap_ready[c] = ready;
            @(posedge clk);
            #1;
            if (c == pulse_c || c == drop_c) valid = 1'b0;
            if (c == rst_c) rst_n = 1'b1;
        end
    endtask

    task automatic cmp_sig(input string name, input logic [MAXC-1:0] got,
                           input logic [MAXC-1:0] want, input int n);
        int mism;
        int first;
        mism  = 0;
        first = -1;
        for (int c = 1; c <= n; c++) begin
            if (got[c] !== want[c]) begin
                if (first < 0) first = c;
                mism = mism + 1;
            end
        end
        checks = checks + 1;
        if (mism != 0) begin
            failures = failures + 1;
            $display("FAIL %s cycle=%0d got=%b want=%b mismatches=%0d",
                     name, first, got[first], want[first], mism);
        end
    endtask

    task automatic cmp_all(input string name, input int n);
        cmp_sig({name, "/tx"},    cap_tx,    exp_tx,    n);
        cmp_sig({name, "/done"},  cap_done,  exp_done,  n);
        cmp_sig({name, "/busy"},  cap_busy,  exp_busy,  n);
        cmp_sig({name, "/ready"}, cap_ready, exp_ready, n);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    logic [0:19] a55a_bits;
    logic [0:19] got_bits;

    initial begin
        // --- reset, then 20 idle cycles ---
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_init();
        capture(20, 0, 0, 0);
        cmp_all("idle", 20);
        $display("idle after reset: 20 cycles checked");

        // --- table of word transactions ---
        vecs[0] = '{"a55a",      16'hA55A, 1'b0, 16'h0000, 0,  0,  T + 3};
        vecs[1] = '{"back2back", 16'h1234, 1'b1, 16'hBEEF, 0,  0,  2 * T + 4};
        vecs[2] = '{"ignore",    16'h1357, 1'b0, 16'h0000, 12, 0,  T + 3};
        vecs[3] = '{"midreset",  16'h8C3E, 1'b0, 16'h0000, 0,  50, T + 10};
        vecs[4] = '{"after_rst", 16'h0001, 1'b0, 16'h0000, 0,  0,  T + 3};
        nvec = 5;
`ifdef UART_TX_PARITY_EN
        vecs[5] = '{"parity",    16'h015A, 1'b0, 16'h0000, 0,  0,  T + 3};
        nvec = 6;
`endif

        for (int i = 0; i < nvec; i++) begin
            check_bit({vecs[i].name, "/ready_pre"}, ready, 1'b1);

            valid = 1'b1;
            data  = vecs[i].d0;
            @(posedge clk);            // transfer edge k
            #1;
            if (vecs[i].hold) data = vecs[i].d1;
            else              valid = 1'b0;

            exp_init();
            exp_word(vecs[i].d0, 1);
            if (vecs[i].hold)      exp_word(vecs[i].d1, T + 2);
            if (vecs[i].rst_c > 0) exp_reset_from(vecs[i].rst_c + 1);

            capture(vecs[i].ncyc, vecs[i].pulse_c, vecs[i].rst_c,
                    vecs[i].hold ? T + 1 : 0);
            cmp_all(vecs[i].name, vecs[i].ncyc);
            $display("word %s data=%h checks=%0d failures=%0d",
                     vecs[i].name, vecs[i].d0, checks, failures);

`ifndef UART_TX_PARITY_EN
            // Hand-written line image of 0xA55A, sampled mid-bit.
            if (i == 0) begin
                a55a_bits = 20'b0010110101_0101001011;
                for (int b = 0; b < 20; b++) got_bits[b] = cap_tx[1 + 4*b + 2];
                checks = checks + 1;
                if (got_bits !== a55a_bits) begin
                    failures = failures + 1;
                    $display("FAIL a55a/midbits got=%b want=%b", got_bits, a55a_bits);
                end
                check_bit("a55a/done_k81", cap_done[81], 1'b1);
                check_bit("a55a/done_k80", cap_done[80], 1'b0);
            end
            if (i == 1) begin
                check_bit("back2back/gap_high", cap_tx[81], 1'b1);
                check_bit("back2back/start2",   cap_tx[82], 1'b0);
            end
`else
            if (i == 5) begin
                check_bit("parity/bit_5a", cap_tx[39], 1'b0);
                check_bit("parity/bit_01", cap_tx[83], 1'b1);
                check_bit("parity/done_k89", cap_done[89], 1'b1);
            end
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Transmit end of the processor's serial debug link: takes an E_BITS-wide result word (accumulator / data-RAM value) from the datapath and serializes it over an 8N1 UART line.
- Bytes go LSB-first; the byte order within a word is low byte first.
- Sits between the processor datapath/control and the board TX pin. It mirrors the operand-input path: this block sends data out of the core, where that path brings data in.

Parameters:
- E_BITS, 16, word width; must be a multiple of 8. NBYTES = E_BITS/8.
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be >= 2.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  word on i_data is offered.
- i_data  input  E_BITS  word to transmit.
- o_ready  output  1  block can accept a word this cycle.
- o_busy  output  1  frame sequence in progress.
- o_done  output  1  one-cycle pulse when the last stop bit completes.
- o_tx  output  1  serial line, idle high, registered.

Behaviour:
- Reset (i_rst_n=0 at a rising edge), effective next cycle:
  - o_tx=1, o_ready=1, o_busy=0, o_done=0.
  - bit/byte/divider counters=0, state IDLE, word register cleared.
  - Reset mid-frame aborts immediately: line high next cycle, word discarded, no o_done.
- Handshake:
  - Transfer occurs on an edge where i_valid && o_ready. i_data is latched into the shift register at that edge.
  - o_ready=0 and o_busy=1 from the next cycle.
  - i_valid while o_ready=0 is ignored; nothing is queued.
- State machine (sequencing lives in the shared package encoding):
  - IDLE: o_ready=1. On transfer -> START, byte index 0.
  - START: o_tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles -> (PARITY if enabled) -> STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. If byte index < NBYTES-1: index+1, shift word right by 8, -> START with no idle gap. Else -> IDLE.
  - Entering IDLE after the last stop bit: o_done=1 for exactly that one cycle, o_ready=1 in the same cycle, o_busy=0.
- Timing:
  - Transfer at edge k: o_tx low from cycle k+1.
  - Frame length F = 10 bits (11 with parity).
  - o_done high in cycle k+1+NBYTES*F*CLKS_PER_BIT.
- Divider counts 0..CLKS_PER_BIT-1 and wraps. The bit advances on the wrap cycle.
- Back-to-back: a transfer in the o_done cycle starts a new START at the next cycle. Minimum idle between words = 1 cycle.
- o_tx is driven from a flop, so no combinational glitch reaches the pin.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between the last data bit and STOP, held CLKS_PER_BIT cycles; F=11.
- Undefined: no PARITY state is generated, F=10, 8N1 exactly.

Decomposition:
- Shared package uart_pkg contains:
  - state encoding localparams ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
  - DATA_BITS=8, LINE_IDLE=1'b1.
  - bit-counter width function (clog2).
- One natural sub-module: uart_baud_div.
  - Inputs: clear, run.
  - Output: one-cycle bit_tick on wrap.
  - Reused by the future RX side.

Test Plan (E_BITS=16, CLKS_PER_BIT=4, parity off unless stated):
- Reset then idle 20 cycles -> o_tx=1, o_ready=1, o_busy=0, o_done=0 throughout.
- Send 0xA55A at edge k -> line bits per 4 cycles: 0, 0,1,0,1,1,0,1,0, 1 (0x5A), then 0, 1,0,1,0,0,1,0,1, 1 (0xA5). o_done pulse only in cycle k+81.
- i_valid held high with 0x1234 then 0xBEEF -> second accepted in the o_done cycle of the first; o_tx high for exactly 1 idle cycle between words; bytes 0x34, 0x12, 0xEF, 0xBE.
- Pulse i_valid with 0xFFFF during DATA of a frame -> ignored; only the original word appears on the line.
- Assert i_rst_n=0 during the second byte's DATA phase -> next cycle o_tx=1, o_ready=1, no o_done; a subsequent word 0x0001 transmits correctly.
- UART_TX_PARITY_EN defined, send 0x015A -> 0x5A has parity bit 0 and 0x01 has parity bit 1; 11-bit frames; o_done in cycle k+89.
